// File: rtl/synaptic_current_accumulator.sv
// Spike-to-current front end for the Izhikevich neuron core: queues presynaptic spike IDs,
// sums their weights into a saturating Q16.16 accumulator and publishes BIAS + ACC each step.
module synaptic_current_accumulator #(
  parameter int unsigned NUM_SYN     = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DECAY_SHIFT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spike_valid,
  input  logic [ADDR_W-1:0] i_spike_id,
  output logic              o_spike_ready,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [31:0]       i_bias,
  input  logic              i_timestep,
  output logic [31:0]       o_i,
  output logic              o_i_valid,
  output logic              o_busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StRun, StDrain, StPublish} state_e;

  state_e              r_state, w_state_d;
  logic [31:0]         r_weight [NUM_SYN];
  logic [ADDR_W-1:0]   r_fifo   [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]     r_count, w_count_d;
  logic [31:0]         r_acc, w_acc_d;
  logic [31:0]         r_i, w_i_d;
  logic                r_i_valid;

  logic                w_full, w_empty, w_push, w_pop;
  logic [31:0]         w_head_weight;
  logic [31:0]         w_acc_decay;

  // Two's-complement add widened to 33 bits, clamped back to the signed 32-bit range.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) begin
      return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return s[31:0];
  endfunction

  assign w_full        = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign o_spike_ready = !w_full && (r_state == StRun);
  assign w_push        = i_spike_valid && o_spike_ready;
  // Weight writes own the cycle; popping resumes once WE drops.
  assign w_pop         = !w_empty && ((r_state == StRun) || (r_state == StDrain)) && !i_we;
  assign w_head_weight = r_weight[r_fifo[r_rd_ptr]];
  assign w_acc_decay   = r_acc - 32'($signed(r_acc) >>> DECAY_SHIFT);

  assign o_i       = r_i;
  assign o_i_valid = r_i_valid;
  assign o_busy    = (r_state == StDrain) || (r_state == StPublish);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_i_d     = r_i;
    if (w_pop) begin
      w_acc_d = sat_add(r_acc, w_head_weight);
    end
    unique case (r_state)
      StRun: begin
        if (i_timestep) w_state_d = StDrain;
      end
      StDrain: begin
        if (w_empty) w_state_d = StPublish;
      end
      StPublish: begin
        w_i_d     = sat_add(i_bias, r_acc);
        w_acc_d   = w_acc_decay;
        w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StRun;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_i       <= '0;
      r_i_valid <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
      for (int k = 0; k < NUM_SYN; k++) r_weight[k] <= '0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_acc     <= w_acc_d;
      r_i       <= w_i_d;
      r_i_valid <= (r_state == StPublish);
      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_spike_id;
        r_wr_ptr         <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (i_we) r_weight[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: doc/synaptic_current_accumulator.md
Name: synaptic_current_accumulator

Overview:
- Upstream stage of the Izhikevich neuron core: converts incoming spike events into the Q16.16 input current I that drives the neuron's I port.
- Spike events (presynaptic IDs) are buffered in a small FIFO and their per-synapse weights are summed into an accumulator.
- On each neuron time step the block publishes I = BIAS + ACC, then applies exponential decay to ACC.

Parameters:
- NUM_SYN, 16, number of synapses (weight entries).
- ADDR_W, 4, synapse ID width; NUM_SYN = 2^ADDR_W.
- FIFO_DEPTH, 4, spike-ID FIFO entries (power of 2).
- DECAY_SHIFT, 2, per-step decay: ACC <= ACC - (ACC >>> DECAY_SHIFT).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset; asserted when 0.
- SPIKE_VALID  in  1  spike event offered.
- SPIKE_ID  in  ADDR_W  presynaptic ID of the offered event.
- SPIKE_READY  out  1  event accepted when SPIKE_VALID && SPIKE_READY at a clock edge.
- WE  in  1  weight write enable.
- WADDR  in  ADDR_W  weight write address.
- WDATA  in  32  signed Q16.16 weight.
- BIAS  in  32  signed Q16.16 constant current added at publish.
- TIMESTEP  in  1  single-cycle request to publish a new current.
- I  out  32  signed Q16.16 current to the neuron.
- I_VALID  out  1  one-cycle pulse: I updated this cycle.
- BUSY  out  1  high in states DRAIN and PUBLISH.

Behaviour:
- Reset (RESET=0, async): state RUN, FIFO empty, ACC=0, I=0, I_VALID=0, BUSY=0. Weights cleared to 0. Reset mid-DRAIN or mid-PUBLISH discards everything; no I_VALID is produced.
- Weight memory: NUM_SYN x 32 registers, written on the edge when WE=1. Reads are combinational. A read of the address being written in the same cycle returns the old value.
- SPIKE_READY = !fifo_full && (state==RUN). It is combinational from registered state. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Pop: one entry per cycle when FIFO is non-empty, state is RUN or DRAIN, and WE=0. Weight-port writes take priority and stall popping.
- Accumulate: on the pop edge, ACC <= sat32(ACC + W[head]). sat32 uses a 33-bit signed sum and clamps to 0x7FFFFFFF or 0x80000000.
- FSM:
  - RUN: TIMESTEP=1 at an edge -> DRAIN.
  - DRAIN: FIFO empty at an edge -> PUBLISH. Pops continue; no new pushes are accepted.
  - PUBLISH: at the edge, I <= sat32(BIAS + ACC) using the ACC value before decay, ACC <= ACC - (ACC >>> DECAY_SHIFT) (arithmetic shift), I_VALID <= 1, state -> RUN.
- I_VALID is registered and lasts exactly one cycle, the cycle after the PUBLISH edge.
- I holds its value between publishes.
- TIMESTEP while in DRAIN or PUBLISH is ignored (not queued).
- TIMESTEP and an accepted push in the same RUN cycle: the push is accepted and is included in this step's sum.
- Latency, empty FIFO: TIMESTEP sampled at edge 0 -> DRAIN; edge 1 -> PUBLISH; edge 2 updates I and raises I_VALID. Each queued entry adds one cycle.
- ACC never wraps; both the accumulate and publish adds saturate.
- Decay of a negative ACC rounds toward -inf through the shift, e.g. -1.0 -> -0.75.

Test Plan:
- Basic sum: W[3]=0x00018000 (1.5), BIAS=0, push ID 3 twice, then TIMESTEP -> I=0x00030000 (3.0), one I_VALID pulse, internal ACC=0x00024000 (2.25).
- Decay chain: continue from the basic-sum case with no spikes, TIMESTEP -> I=0x00024000. Next TIMESTEP -> I=0x0001B000 (1.6875).
- Saturation and bias: W[1]=0x40000000, 3 spikes on ID 1, BIAS=0x00010000 -> I=0x7FFFFFFF. With W[1]=0xC0000000 and the same 3 spikes -> I=0x80000000 + bias clamp check, i.e. I=0x80010000.
- Backpressure: hold WE=1 for 6 cycles while SPIKE_VALID=1 -> exactly 4 pushes accepted, then SPIKE_READY=0. Release WE -> FIFO drains one per cycle. TIMESTEP afterwards -> I equals the sum of the 4 weights.
- Timestep handling: push 2 IDs then TIMESTEP in the same cycle as the second push -> SPIKE_READY=0 during DRAIN, BUSY=1. I_VALID occurs 2 cycles after the pops finish, and a second TIMESTEP during DRAIN produces no extra pulse.
- Reset mid-operation: pull RESET low in DRAIN -> I=0, I_VALID=0, BUSY=0 immediately. After release, TIMESTEP -> I=BIAS.
